// File: rtl/mem_line_arbiter.sv
// Line arbiter and serializer between the I/D caches and the system bus.
// Grants one whole-line request at a time, round-robin between the two cache
// ports, and moves the 512-bit line as eight 64-bit beats, lowest word first.
module mem_line_arbiter #(
  parameter int AddrWidth = 64,
  parameter int BeatWidth = 64,
  parameter int Beats     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  // instruction-cache port
  input  logic                         irequest,
  input  logic                         iwrenable,
  input  logic [AddrWidth-1:0]         iaddr,
  input  logic [BeatWidth*Beats-1:0]   iwdata,
  output logic                         ireqack,
  output logic [BeatWidth*Beats-1:0]   irdata,
  output logic                         idone,
  // data-cache port
  input  logic                         drequest,
  input  logic                         dwrenable,
  input  logic [AddrWidth-1:0]         daddr,
  input  logic [BeatWidth*Beats-1:0]   dwdata,
  output logic                         dreqack,
  output logic [BeatWidth*Beats-1:0]   drdata,
  output logic                         ddone,
  // system bus
  output logic                         bus_req,
  input  logic                         bus_reqack,
  output logic [AddrWidth-1:0]         bus_addr,
  output logic                         bus_wen,
  output logic                         bus_wvalid,
  input  logic                         bus_wready,
  output logic [BeatWidth-1:0]         bus_wdata,
  input  logic                         bus_rvalid,
  input  logic [BeatWidth-1:0]         bus_rdata
);

  localparam int LineWidth  = BeatWidth * Beats;
  localparam int CntWidth   = $clog2(Beats);
  localparam int OffsetBits = $clog2(LineWidth / 8);
  localparam logic [CntWidth-1:0]  LastBeat = CntWidth'(Beats - 1);
  localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'((64'd1 << OffsetBits) - 64'd1);

  typedef enum logic [1:0] {IDLE, BUS_REQ, WR_BEATS, RD_BEATS} state_t;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

  state_t                 state, state_d;
  logic [CntWidth-1:0]    cnt, cnt_d;
  port_t                  last, last_d;      // port granted most recently
  port_t                  port, port_d;      // port owning the current transaction
  port_t                  grant;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   wen_q, wen_d;
  logic [LineWidth-1:0]   wdata_q, wdata_d;
  logic [LineWidth-1:0]   line_buf;
  logic                   ireqack_d, dreqack_d, idone_d, ddone_d;
  logic                   bus_req_d, bus_wvalid_d;
  logic [BeatWidth-1:0]   bus_wdata_d;
  logic                   capture;           // store bus_rdata into line_buf[cnt]

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d      = state;
    cnt_d        = cnt;
    last_d       = last;
    port_d       = port;
    grant        = PORT_I;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    ireqack_d    = 1'b0;
    dreqack_d    = 1'b0;
    idone_d      = 1'b0;
    ddone_d      = 1'b0;
    bus_req_d    = bus_req;
    bus_wvalid_d = bus_wvalid;
    bus_wdata_d  = bus_wdata;
    capture      = 1'b0;

    unique case (state)
      IDLE: begin
        if (irequest || drequest) begin
          // On a tie the port that was not served last wins.
          grant     = (drequest && (!irequest || last == PORT_I)) ? PORT_D : PORT_I;
          port_d    = grant;
          last_d    = grant;
          addr_d    = ((grant == PORT_D) ? daddr : iaddr) & LineMask;
          wen_d     = (grant == PORT_D) ? dwrenable : iwrenable;
          wdata_d   = (grant == PORT_D) ? dwdata : iwdata;
          ireqack_d = (grant == PORT_I);
          dreqack_d = (grant == PORT_D);
          bus_req_d = 1'b1;
          state_d   = BUS_REQ;
        end
      end

      BUS_REQ: begin
        if (bus_reqack) begin
          bus_req_d = 1'b0;
          cnt_d     = '0;
          if (wen_q) begin
            bus_wvalid_d = 1'b1;
            bus_wdata_d  = wdata_q[BeatWidth-1:0];
            state_d      = WR_BEATS;
          end else begin
            state_d = RD_BEATS;
          end
        end
      end

      WR_BEATS: begin
        if (bus_wvalid && bus_wready) begin
          if (cnt == LastBeat) begin
            bus_wvalid_d = 1'b0;
            idone_d      = (port == PORT_I);
            ddone_d      = (port == PORT_D);
            state_d      = IDLE;
          end else begin
            cnt_d       = cnt + CntWidth'(1);
            bus_wdata_d = wdata_q[int'(cnt_d) * BeatWidth +: BeatWidth];
          end
        end
      end

      RD_BEATS: begin
        if (bus_rvalid) begin
          capture = 1'b1;
          if (cnt == LastBeat) begin
            idone_d = (port == PORT_I);
            ddone_d = (port == PORT_D);
            state_d = IDLE;
          end else begin
            cnt_d = cnt + CntWidth'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, transaction context and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= PORT_I;
      port       <= PORT_I;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      ireqack    <= 1'b0;
      dreqack    <= 1'b0;
      idone      <= 1'b0;
      ddone      <= 1'b0;
      bus_req    <= 1'b0;
      bus_wvalid <= 1'b0;
      bus_wdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state      <= state_d;
      cnt        <= cnt_d;
      last       <= last_d;
      port       <= port_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      ireqack    <= ireqack_d;
      dreqack    <= dreqack_d;
      idone      <= idone_d;
      ddone      <= ddone_d;
      bus_req    <= bus_req_d;
      bus_wvalid <= bus_wvalid_d;
      bus_wdata  <= bus_wdata_d;
    end
  end

  // Shared read-line buffer, filled one beat at a time.
  always_ff @(posedge clk) begin
    // NOTE: the line buffer is cleared on reset because both rdata ports
    // expose it directly and must read as zero after reset.
    if (reset) begin
      line_buf <= '0;
    end else if (capture) begin
      line_buf[int'(cnt) * BeatWidth +: BeatWidth] <= bus_rdata;
    end
  end

  assign bus_addr = addr_q;
  assign bus_wen  = wen_q;
  assign irdata   = line_buf;
  assign drdata   = line_buf;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter: directed scenarios followed by
// randomized traffic, a bus responder, and a scoreboard-driven monitor.
module tb_mem_line_arbiter;

  localparam bit P_I = 1'b0;
  localparam bit P_D = 1'b1;
  localparam logic [63:0] LINE_MASK = 64'hFFFF_FFFF_FFFF_FFC0;

  typedef struct { bit port; int issue; int lat; } ack_t;
  typedef struct { logic [63:0] addr; bit wen; logic [511:0] line; } bus_t;
  typedef struct { bit port; bit wen; logic [511:0] line; int issue; int lat; } done_t;
  typedef struct { bit wen; logic [63:0] addr; logic [511:0] line; } req_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         irequest, iwrenable, drequest, dwrenable;
  logic [63:0]  iaddr, daddr;
  logic [511:0] iwdata, dwdata, irdata, drdata;
  logic         ireqack, dreqack, idone, ddone;
  logic         bus_req, bus_reqack, bus_wen, bus_wvalid, bus_wready, bus_rvalid;
  logic [63:0]  bus_addr, bus_wdata, bus_rdata;

  mem_line_arbiter dut (
    .clk(clk), .reset(reset),
    .irequest(irequest), .iwrenable(iwrenable), .iaddr(iaddr), .iwdata(iwdata),
    .ireqack(ireqack), .irdata(irdata), .idone(idone),
    .drequest(drequest), .dwrenable(dwrenable), .daddr(daddr), .dwdata(dwdata),
    .dreqack(dreqack), .drdata(drdata), .ddone(ddone),
    .bus_req(bus_req), .bus_reqack(bus_reqack), .bus_addr(bus_addr), .bus_wen(bus_wen),
    .bus_wvalid(bus_wvalid), .bus_wready(bus_wready), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard queues and reference state.
  ack_t  exp_ack[$];
  bus_t  exp_bus[$];
  done_t exp_done[$];
  bit           model_last;        // port served most recently
  logic [511:0] model_buf;         // expected line-buffer contents

  // Bus responder configuration.
  bit  rand_mode = 1'b0;
  int  ack_delay = 0;              // -1 = random
  bit  stray     = 1'b0;
  bit  pat_q[$];                   // per-cycle ready/valid pattern, then all ones
  int  last_beat_cyc = 0;
  int  rd_sent = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] seq_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.wen  = 1'($urandom_range(0, 1));
    r.addr = {$urandom, $urandom};
    r.line = rand_line();
    return r;
  endfunction

  function automatic bit next_pat();
    if (rand_mode) return ($urandom_range(0, 9) < 7);
    if (pat_q.size() != 0) return pat_q.pop_front();
    return 1'b1;
  endfunction

  task automatic idle_bus();
    bus_reqack = 1'b0;
    bus_rvalid = 1'b0;
    bus_wready = 1'b0;
  endtask

  // Serve one bus transaction: accept the command, then move eight beats.
  task automatic serve();
    bus_t         b;
    logic [63:0]  a0;
    logic         w0;
    bit           stable, hold_ok, p;
    int           wait_n, k, guard;
    logic [511:0] got;
    if (exp_bus.size() == 0) begin
      check("unexpected_bus_req", bus_req, 1'b0);
      return;
    end
    b = exp_bus.pop_front();
    rd_sent = 0;
    check("bus_addr", bus_addr, b.addr);
    check("bus_wen", bus_wen, b.wen);
    a0 = bus_addr;
    w0 = bus_wen;
    stable = 1'b1;
    wait_n = (ack_delay < 0) ? $urandom_range(0, 4) : ack_delay;
    for (int i = 0; i < wait_n; i++) begin
      bus_rvalid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_rdata  = {$urandom, $urandom};
      @(negedge clk);
      if (reset) begin idle_bus(); return; end
      if (!(bus_req === 1'b1 && bus_addr === a0 && bus_wen === w0)) stable = 1'b0;
    end
    if (wait_n > 0) check("bus_cmd_stable", stable, 1'b1);
    bus_reqack = 1'b1;
    bus_rvalid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    bus_rdata  = {$urandom, $urandom};
    @(negedge clk);
    if (reset) begin idle_bus(); return; end
    bus_reqack = 1'b0;
    bus_rvalid = 1'b0;
    check("bus_req_drop", bus_req, 1'b0);
    check("buf_hold", drdata, model_buf);
    k = 0;
    guard = 0;
    got = '0;
    hold_ok = 1'b1;
    if (b.wen) begin
      while (k < 8 && guard < 300) begin
        p = next_pat();
        bus_wready = p;
        bus_rvalid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_rdata  = {$urandom, $urandom};
        if (bus_wvalid !== 1'b1 || bus_wdata !== b.line[k*64 +: 64]) hold_ok = 1'b0;
        if (bus_wvalid === 1'b1 && p) begin
          got[k*64 +: 64] = bus_wdata;
          if (k == 7) last_beat_cyc = cyc;
          k++;
        end
        @(negedge clk);
        if (reset) begin idle_bus(); return; end
        guard++;
      end
      idle_bus();
      check("wr_line", got, b.line);
      check("wr_beat_hold", hold_ok, 1'b1);
      check("wvalid_drop", bus_wvalid, 1'b0);
    end else begin
      while (k < 8 && guard < 300) begin
        p = next_pat();
        bus_rvalid = p;
        bus_rdata  = p ? b.line[k*64 +: 64] : {$urandom, $urandom};
        if (p) begin
          if (k == 7) last_beat_cyc = cyc;
          k++;
          rd_sent = k;
        end
        @(negedge clk);
        if (reset) begin idle_bus(); return; end
        guard++;
      end
      idle_bus();
    end
    if (guard >= 300) check("beat_budget", k, 8);
  endtask

  // Bus responder.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus_req === 1'b1) serve();
    end
  end

  // Monitor: compares every reqack and done pulse against the scoreboard.
  initial begin
    ack_t  a;
    done_t d;
    logic [511:0] exp_line;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ireqack || dreqack) begin
          if (exp_ack.size() == 0) begin
            check("unexpected_reqack", {ireqack, dreqack}, 2'b00);
          end else begin
            a = exp_ack.pop_front();
            check("reqack_port", {ireqack, dreqack}, a.port ? 2'b01 : 2'b10);
            if (a.lat >= 0) check("reqack_latency", cyc - a.issue, a.lat);
          end
        end
        if (idone || ddone) begin
          if (exp_done.size() == 0) begin
            check("unexpected_done", {idone, ddone}, 2'b00);
          end else begin
            d = exp_done.pop_front();
            check("done_port", {idone, ddone}, d.port ? 2'b01 : 2'b10);
            check("done_after_last_beat", cyc, last_beat_cyc + 1);
            if (d.lat >= 0) check("done_latency", cyc - d.issue, d.lat);
            exp_line = d.wen ? model_buf : d.line;
            check("irdata", irdata, exp_line);
            check("drdata", drdata, exp_line);
            model_buf = exp_line;
          end
        end
      end
    end
  end

  // Issue one request, or a simultaneous pair, and wait for all to complete.
  task automatic issue(input bit do_i, input bit do_d, input req_t ri, input req_t rd,
                       input int a0, input int d0, input int a1, input int d1);
    bit   order[2];
    int   n, guard;
    req_t r;
    n = 0;
    if (do_i && do_d) begin
      order[0] = (model_last == P_I) ? P_D : P_I;
      order[1] = ~order[0];
      n = 2;
    end else if (do_d) begin
      order[0] = P_D; n = 1;
    end else if (do_i) begin
      order[0] = P_I; n = 1;
    end
    for (int k = 0; k < n; k++) begin
      r = order[k] ? rd : ri;
      exp_ack.push_back('{order[k], cyc, (k == 0) ? a0 : a1});
      exp_bus.push_back('{r.addr & LINE_MASK, r.wen, r.line});
      exp_done.push_back('{order[k], r.wen, r.line, cyc, (k == 0) ? d0 : d1});
      model_last = order[k];
    end
    iwrenable = ri.wen; iaddr = ri.addr; iwdata = ri.wen ? ri.line : rand_line();
    dwrenable = rd.wen; daddr = rd.addr; dwdata = rd.wen ? rd.line : rand_line();
    irequest = do_i;
    drequest = do_d;
    guard = 0;
    do begin
      @(negedge clk);
      if (ireqack) irequest = 1'b0;
      if (dreqack) drequest = 1'b0;
      guard++;
    end while ((irequest || drequest || exp_done.size() != 0) && guard < 3000);
    if (guard >= 3000) begin
      check("txn_timeout", exp_done.size(), 0);
      irequest = 1'b0;
      drequest = 1'b0;
      exp_ack.delete(); exp_bus.delete(); exp_done.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    irequest = 1'b0;
    drequest = 1'b0;
    @(negedge clk);
    check("reset_ctrl",
          {ireqack, dreqack, idone, ddone, bus_req, bus_wen, bus_wvalid, bus_addr, bus_wdata},
          '0);
    check("reset_irdata", irdata, '0);
    check("reset_drdata", drdata, '0);
    @(negedge clk);
    reset = 1'b0;
    exp_ack.delete(); exp_bus.delete(); exp_done.delete();
    model_last = P_I;
    model_buf  = '0;
  endtask

  task automatic set_bus(input bit rm, input int delay, input bit st);
    rand_mode = rm;
    ack_delay = delay;
    stray     = st;
    pat_q.delete();
  endtask

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    req_t ri, rd, rq;
    int   sel, saw_done;
    reset = 1'b1;
    irequest = 1'b0; drequest = 1'b0; iwrenable = 1'b0; dwrenable = 1'b0;
    iaddr = '0; daddr = '0; iwdata = '0; dwdata = '0;
    bus_reqack = 1'b0; bus_wready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    do_reset();

    // D read, zero-wait bus, words 0x10..0x17.
    set_bus(1'b0, 0, 1'b0);
    ri = rand_req();
    rd = '{1'b0, 64'h1000_0047, seq_line(64'h10)};
    issue(1'b0, 1'b1, ri, rd, 1, 10, -1, -1);

    // I write, wready low for two cycles on the third beat.
    set_bus(1'b0, 0, 1'b0);
    pat_q = '{1'b1, 1'b1, 1'b0, 1'b0};
    ri = '{1'b1, 64'h2000_0000, seq_line(64'hA0)};
    issue(1'b1, 1'b0, ri, rd, 1, 12, -1, -1);

    // Simultaneous reads after reset: D wins, I follows from the done cycle.
    do_reset();
    set_bus(1'b0, 0, 1'b0);
    ri = '{1'b0, 64'h0000_3000, rand_line()};
    rd = '{1'b0, 64'h0000_4000, rand_line()};
    issue(1'b1, 1'b1, ri, rd, 1, 10, 11, 20);

    // D alone, then a tie that now favours I.
    rd = '{1'b0, 64'h0000_5040, rand_line()};
    issue(1'b0, 1'b1, ri, rd, 1, 10, -1, -1);
    ri = '{1'b0, 64'h0000_6080, rand_line()};
    rd = '{1'b0, 64'h0000_70C0, rand_line()};
    issue(1'b1, 1'b1, ri, rd, 1, 10, 11, 20);

    // Read with gaps and stray rvalid while waiting for bus_reqack.
    set_bus(1'b0, 3, 1'b1);
    pat_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rd = '{1'b0, 64'h0000_8000, rand_line()};
    issue(1'b0, 1'b1, ri, rd, 1, 16, -1, -1);

    // Reset in the middle of a read's beats.
    set_bus(1'b0, 0, 1'b0);
    rq = '{1'b0, 64'h0000_9000, rand_line()};
    exp_ack.push_back('{P_D, cyc, 1});
    exp_bus.push_back('{rq.addr, 1'b0, rq.line});
    dwrenable = 1'b0; daddr = rq.addr; drequest = 1'b1;
    for (int i = 0; i < 40 && rd_sent < 5; i++) begin
      @(negedge clk);
      if (dreqack) drequest = 1'b0;
    end
    @(negedge clk);
    do_reset();
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (idone || ddone || bus_req) saw_done++;
    end
    check("no_done_after_abort", saw_done, 0);

    // A fresh D read after the abort completes normally.
    rd = '{1'b0, 64'h0000_A000, rand_line()};
    issue(1'b0, 1'b1, ri, rd, 1, 10, -1, -1);

    // bus_reqack stalled for 20 cycles on a D write.
    set_bus(1'b0, 20, 1'b0);
    rd = '{1'b1, 64'h0000_B03F, rand_line()};
    issue(1'b0, 1'b1, ri, rd, 1, 30, -1, -1);

    // Randomized traffic: singles and ties, random bus timing and strays.
    for (int t = 0; t < 30; t++) begin
      set_bus(1'b1, -1, 1'b1);
      sel = $urandom_range(1, 3);
      ri  = rand_req();
      rd  = rand_req();
      issue(sel[0], sel[1], ri, rd, -1, -1, -1, -1);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
